// File: rtl/atm_balance_arbiter.sv
// atm_balance_arbiter: round-robin arbiter serialising deposits/withdrawals against one shared balance.
// Optional ATM_ARB_TXN_COUNT_EN enables the saturating successful-transaction counter on txn_count.
module atm_balance_arbiter #(
   parameter int N_REQ = 4,
   parameter int BAL_W = 64,
   parameter int AMT_W = 32,
   parameter logic [BAL_W-1:0] INIT_BALANCE = 64'h0000_0000_5ADB_6DFD
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic [N_REQ-1:0]       req,
   input  logic [N_REQ-1:0]       op_type,
   input  logic [N_REQ*AMT_W-1:0] amount,
   output logic [N_REQ-1:0]       grant,
   output logic                   done,
   output logic                   result_ok,
   output logic                   insufficient,
   output logic                   overflow,
   output logic [BAL_W-1:0]       balance,
   output logic                   busy,
   output logic [15:0]            txn_count
);
   localparam int IW = $clog2(N_REQ);
   typedef enum logic [2:0] {IDLE = 3'b001, EXEC = 3'b010, DONE = 3'b100} state_t;
   state_t state, stateNext;
   logic [IW-1:0] rrPtr, winner, pick;
   logic opLat;
   logic [AMT_W-1:0] amtLat;
   logic [BAL_W-1:0] amtExt;
   logic [BAL_W:0] sum;
   logic isInsuff, isOvf, isOk;
   // Scanning downward leaves the lowest offset from rrPtr as the final pick.
   always_comb begin
      pick = rrPtr;
      for (int k = N_REQ - 1; k >= 0; k--)
         if (req[(int'(rrPtr) + k) % N_REQ]) pick = IW'((int'(rrPtr) + k) % N_REQ);
   end
   assign amtExt   = BAL_W'(amtLat);
   assign sum      = {1'b0, balance} + {1'b0, amtExt};
   assign isInsuff = opLat && (amtExt > balance);
   assign isOvf    = !opLat && sum[BAL_W];
   assign isOk     = !isInsuff && !isOvf;
   assign busy     = (state != IDLE);
   always_ff @(posedge clock)
      state <= !reset ? IDLE : stateNext;
   always_comb begin
      stateNext = state == IDLE ? (|req ? EXEC : IDLE) :
                  state == EXEC ? DONE :
                  (state == DONE && req[winner]) ? DONE : IDLE;
   end
   always_ff @(posedge clock) begin
      if (!reset) begin
         grant        <= '0;
         done         <= 1'b0;
         result_ok    <= 1'b0;
         insufficient <= 1'b0;
         overflow     <= 1'b0;
         balance      <= INIT_BALANCE;
         rrPtr        <= '0;
         winner       <= '0;
         opLat        <= 1'b0;
         amtLat       <= '0;
      end else begin
         case (state)
            IDLE: if (|req) begin
               winner <= pick;
               opLat  <= op_type[pick];
               amtLat <= amount[pick*AMT_W +: AMT_W];
               grant  <= N_REQ'(1) << pick;
            end
            EXEC: begin
               done         <= 1'b1;
               result_ok    <= isOk;
               insufficient <= isInsuff;
               overflow     <= isOvf;
               if (isOk) balance <= opLat ? balance - amtExt : sum[BAL_W-1:0];
            end
            DONE: if (!req[winner]) begin
               grant        <= '0;
               done         <= 1'b0;
               result_ok    <= 1'b0;
               insufficient <= 1'b0;
               overflow     <= 1'b0;
               rrPtr        <= (winner == IW'(N_REQ - 1)) ? '0 : winner + 1'b1;
            end
            default: ;
         endcase
      end
   end
`ifdef ATM_ARB_TXN_COUNT_EN
   always_ff @(posedge clock)
      if (!reset) txn_count <= '0;
      else if (state == EXEC && isOk && txn_count != 16'hFFFF) txn_count <= txn_count + 16'd1;
`else
   assign txn_count = '0;
`endif
endmodule

// File: tb/tb_atm_balance_arbiter.sv
// tb_atm_balance_arbiter: directed and randomized checks of atm_balance_arbiter against a behavioural account model.
module tb_atm_balance_arbiter;
   localparam logic [63:0] INIT = 64'h0000_0000_5ADB_6DFD;
   localparam logic [63:0] INIT2 = 64'hFFFF_FFFF_0000_0000;
   logic clock, reset;
   logic [3:0] req, opType, grant;
   logic [127:0] amount;
   logic done, resultOk, insufficient, overflow, busy;
   logic [63:0] balance;
   logic [15:0] txnCount;
   logic [3:0] req2, opType2, grant2;
   logic [127:0] amount2;
   logic done2, resultOk2, insufficient2, overflow2, busy2;
   logic [63:0] balance2;
   logic [15:0] txnCount2;
   int nChecks = 0, nFail = 0, cyc = 0, gCyc = 0, modelCnt = 0, modelPtr = 0, e, w;
   logic [63:0] modelBal = INIT;
   logic ok, ins, ovf;
   logic [3:0] mask, ops;
   logic [31:0] amts [4];

   atm_balance_arbiter dut (.clock(clock), .reset(reset), .req(req), .op_type(opType), .amount(amount),
      .grant(grant), .done(done), .result_ok(resultOk), .insufficient(insufficient), .overflow(overflow),
      .balance(balance), .busy(busy), .txn_count(txnCount));
   atm_balance_arbiter #(.INIT_BALANCE(INIT2)) dut2 (.clock(clock), .reset(reset), .req(req2),
      .op_type(opType2), .amount(amount2), .grant(grant2), .done(done2), .result_ok(resultOk2),
      .insufficient(insufficient2), .overflow(overflow2), .balance(balance2), .busy(busy2), .txn_count(txnCount2));

   initial clock = 1'b0;
   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] want);
      nChecks++;
      assert (obs === want) else begin
         nFail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, want);
      end
   endtask

   function automatic logic [63:0] expTxn();
`ifdef ATM_ARB_TXN_COUNT_EN
      return 64'(modelCnt > 65535 ? 65535 : modelCnt);
`else
      return 64'd0;
`endif
   endfunction

   // Account rules: withdraw only if funds cover it, deposit only if it fits in 64 bits.
   task automatic modelTxn(input logic wd, input logic [31:0] a, output logic mOk, output logic mIns, output logic mOvf);
      mIns = wd && (64'(a) > modelBal);
      mOvf = !wd && (64'(a) > (64'hFFFF_FFFF_FFFF_FFFF - modelBal));
      mOk = !mIns && !mOvf;
      if (mOk) begin
         modelBal = wd ? modelBal - 64'(a) : modelBal + 64'(a);
         modelCnt++;
      end
   endtask

   task automatic modelReset();
      modelBal = INIT;
      modelCnt = 0;
      modelPtr = 0;
   endtask

   task automatic checkResult(input string tag);
      check({tag, " done"}, 64'(done), 64'd1);
      check({tag, " result_ok"}, 64'(resultOk), 64'(ok));
      check({tag, " insufficient"}, 64'(insufficient), 64'(ins));
      check({tag, " overflow"}, 64'(overflow), 64'(ovf));
      check({tag, " balance"}, balance, modelBal);
      check({tag, " txn_count"}, 64'(txnCount), expTxn());
   endtask

   task automatic doTxn(input int t, input logic wd, input logic [31:0] a, input string tag);
      opType[t] = wd;
      amount[t*32 +: 32] = a;
      req[t] = 1'b1;
      step();
      check({tag, " grant"}, 64'(grant), 64'(1 << t));
      check({tag, " busy"}, 64'(busy), 64'd1);
      modelTxn(wd, a, ok, ins, ovf);
      step();
      checkResult(tag);
      req[t] = 1'b0;
      step();
      check({tag, " grant clear"}, 64'(grant), 64'd0);
      check({tag, " done clear"}, 64'(done), 64'd0);
      modelPtr = (t + 1) % 4;
   endtask

   task automatic doReset();
      reset = 1'b0;
      step();
      reset = 1'b1;
      modelReset();
   endtask

   initial begin
      reset = 1'b0; req = '0; opType = '0; amount = '0;
      req2 = '0; opType2 = '0; amount2 = '0;
      step(); step();
      check("reset grant", 64'(grant), 64'd0);
      check("reset done", 64'(done), 64'd0);
      check("reset flags", 64'({resultOk, insufficient, overflow}), 64'd0);
      check("reset busy", 64'(busy), 64'd0);
      check("reset balance", balance, INIT);
      check("reset txn_count", 64'(txnCount), 64'd0);
      reset = 1'b1;
      modelReset();
      doTxn(0, 1'b0, 32'd100, "deposit");
      doReset();
      doTxn(1, 1'b1, 32'hFFFF_FFFF, "insufficient");
      doReset();
      doTxn(0, 1'b1, 32'h5ADB_6DFD, "exact");
      // Round robin with all four terminals contending.
      doReset();
      opType = '0;
      for (int i = 0; i < 4; i++) amount[i*32 +: 32] = 32'(10 * (i + 1));
      req = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         e = k % 4;
         step();
         check("rr grant", 64'(grant), 64'(1 << e));
         if (k > 0) check("rr period", 64'(cyc - gCyc), 64'd4);
         gCyc = cyc;
         modelTxn(1'b0, 32'(10 * (e + 1)), ok, ins, ovf);
         step();
         checkResult("rr");
         step();
         req[e] = 1'b0;
         step();
         check("rr idle", 64'(grant), 64'd0);
         if (k < 4) req[e] = 1'b1;
      end
      req = '0;
      modelPtr = 1;
      // Random contention and amounts.
      for (int n = 0; n < 40; n++) begin
         mask = 4'($urandom_range(1, 15));
         for (int i = 0; i < 4; i++) begin
            ops[i] = 1'($urandom);
            amts[i] = ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 2000000);
            opType[i] = ops[i];
            amount[i*32 +: 32] = amts[i];
         end
         req = mask;
         w = -1;
         for (int k = 0; k < 4; k++) if (w < 0 && mask[(modelPtr + k) % 4]) w = (modelPtr + k) % 4;
         step();
         check("rand grant", 64'(grant), 64'(1 << w));
         modelTxn(ops[w], amts[w], ok, ins, ovf);
         step();
         checkResult("rand");
         req = '0;
         step();
         check("rand idle", 64'({grant, done, resultOk, insufficient, overflow}), 64'd0);
         modelPtr = (w + 1) % 4;
      end
      // Reset while a transaction sits in DONE.
      opType[2] = 1'b0;
      amount[64 +: 32] = 32'd7;
      req[2] = 1'b1;
      step(); step(); step();
      reset = 1'b0;
      step();
      check("midreset outputs", 64'({grant, done, resultOk, insufficient, overflow, busy}), 64'd0);
      check("midreset balance", balance, INIT);
      check("midreset txn_count", 64'(txnCount), 64'd0);
      reset = 1'b1;
      modelReset();
      opType[0] = 1'b0;
      amount[31:0] = 32'd5;
      req = 4'b0101;
      step();
      check("midreset regrant", 64'(grant), 64'b0001);
      modelTxn(1'b0, 32'd5, ok, ins, ovf);
      step();
      checkResult("midreset txn");
      req = '0;
      step();
      // Overflow on the instance preloaded near the top of the range.
      req2[0] = 1'b1;
      amount2[31:0] = 32'hFFFF_FFF6;
      step(); step();
      check("ovf fill ok", 64'(resultOk2), 64'd1);
      check("ovf fill balance", balance2, 64'hFFFF_FFFF_FFFF_FFF6);
      req2 = '0;
      step();
      req2[0] = 1'b1;
      amount2[31:0] = 32'd20;
      step(); step();
      check("ovf flag", 64'(overflow2), 64'd1);
      check("ovf result_ok", 64'(resultOk2), 64'd0);
      check("ovf balance", balance2, 64'hFFFF_FFFF_FFFF_FFF6);
`ifdef ATM_ARB_TXN_COUNT_EN
      check("ovf txn_count", 64'(txnCount2), 64'd1);
`else
      check("ovf txn_count", 64'(txnCount2), 64'd0);
`endif
      req2 = '0;
      step();
      check("ovf idle", 64'({grant2, done2, overflow2}), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
      $finish;
   end
endmodule

// File: doc/atm_balance_arbiter.md
# atm_balance_arbiter

Shared-account arbiter for the ATM controller subsystem. Up to N ATM terminal controllers request deposit or withdrawal transactions against a single 64-bit account balance. The block grants access round-robin, performs the arithmetic atomically and returns a result handshake. It is the only writer of the balance register.

## Interface
Parameters:
- N_REQ, 4, number of requesting terminals (2..8)
- BAL_W, 64, balance width in bits
- AMT_W, 32, transaction amount width in bits
- INIT_BALANCE, 64'h0000_0000_5ADB_6DFD, balance loaded on reset

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-low
- req  in  N_REQ  per-terminal request; held high until done is seen
- op_type  in  N_REQ  per-terminal operation: 1 = withdrawal, 0 = deposit
- amount  in  N_REQ*AMT_W  flattened amounts; terminal i uses bits [i*AMT_W +: AMT_W]
- grant  out  N_REQ  one-hot grant to the active terminal
- done  out  1  transaction complete; result flags valid
- result_ok  out  1  balance was updated
- insufficient  out  1  withdrawal rejected because amount > balance
- overflow  out  1  deposit rejected because the sum exceeds BAL_W bits
- balance  out  BAL_W  current account balance
- busy  out  1  high in any state other than IDLE
- txn_count  out  16  completed successful transactions (see Configuration)

## Operation
- Reset (reset low at a rising edge) sets:
  - state = IDLE, rr_ptr = 0
  - grant, done, result_ok, insufficient, overflow, busy and txn_count all 0
  - balance = INIT_BALANCE
- A reset in the middle of a transaction aborts it. No partial update is kept.
- The FSM is encoded one-hot with three states:
  - **IDLE**: if any req bit is high, select the winner by round-robin. The search starts at index rr_ptr and wraps through N_REQ-1 back to 0.
    - Latch the winner index, its op_type and its amount.
    - Set grant[winner] and go to EXEC.
    - If no req bit is high, stay in IDLE.
  - **EXEC**: one cycle, always completes even if req drops.
    - Withdrawal: if amount > balance, set insufficient = 1 and leave balance unchanged. Otherwise balance -= amount and result_ok = 1. amount == balance is accepted and leaves balance = 0.
    - Deposit: the sum is computed at BAL_W+1 bits. If the carry is set, set overflow = 1 and leave balance unchanged. Otherwise balance += amount and result_ok = 1.
    - Set done = 1 and go to DONE.
  - **DONE**: hold done, the flags and grant.
    - When req[winner] is sampled low, go to IDLE and clear grant, done and all flags.
    - Set rr_ptr = (winner+1) mod N_REQ.
- amount is zero-extended to BAL_W before the compare and the arithmetic.
- Requests from non-granted terminals are ignored until IDLE. Their req bits simply stay pending.
- At most one flag among result_ok, insufficient and overflow is high at any time.

## Timing
- Edge 0: IDLE samples req. After the edge, grant and busy are high.
- Edge 1: EXEC. After the edge, balance, done and the flags are valid.
- Request-to-done latency is 2 cycles.
- The edge that samples req[winner] low returns the FSM to IDLE with all outputs cleared.
- The next grant comes no earlier than the following edge. IDLE always lasts at least one cycle between transactions.
- Back-to-back throughput: 4 cycles per transaction when requesters drop req in the cycle after seeing done.
- If several requests arrive on the same edge, the one nearest rr_ptr (at or after it) wins.
- balance is registered and changes only at the EXEC edge.

## Configuration
- Macro: ATM_ARB_TXN_COUNT_EN.
- Defined: txn_count increments at the EXEC edge whenever result_ok is set. It saturates at 16'hFFFF and clears on reset.
- Not defined: the counter logic is removed and txn_count is tied to 0.
- The port is present in both builds.

## Test plan
- Single deposit: reset; req[0]=1, op_type[0]=0, amount 100.
  - Expect grant=4'b0001 after 1 edge.
  - Expect done=1, result_ok=1, balance=INIT_BALANCE+100 after 2 edges.
  - Drop req[0]; expect grant=0 and done=0 after the next edge.
- Insufficient funds: req[1] withdrawal of amount 32'hFFFF_FFFF with balance = INIT_BALANCE.
  - Expect insufficient=1, result_ok=0 and balance unchanged.
- Exact withdrawal: withdraw amount = 32'h5ADB_6DFD from reset.
  - Expect result_ok=1 and balance=0.
  - With ATM_ARB_TXN_COUNT_EN defined, expect txn_count=1.
- Round-robin: all four req held high; each terminal drops req after seeing its done and re-raises it one cycle later.
  - Expect grant order 0, 1, 2, 3, 0, with 4 cycles per transaction.
- Overflow: force balance to 2^64-10 via a sequence of deposits, then deposit 20.
  - Expect overflow=1, balance unchanged and txn_count not incremented.
- Reset mid-operation: assert reset low during DONE.
  - Expect all outputs 0, balance=INIT_BALANCE and the next grant to go to terminal 0.
